riscv_decode_stage: RTL

//  Parametrised decode stage for the pipelined RV32I/E core, between fetch and execute.

---
 rtl/riscv_decode_stage_pkg.sv | 41 ++++
 rtl/riscv_decode_stage_hazard.sv | 22 ++
 rtl/riscv_decode_stage.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/riscv_decode_stage_pkg.sv
// Shared decode constants: NOP encoding, RV32I base opcodes and immediate format selection.
package riscv_decode_stage_pkg;

  localparam int          XLEN_DEF = 32;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OP_REG:                                            fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM:     fmt = FMT_I;
      OP_STORE:                                          fmt = FMT_S;
      OP_BRANCH:                                         fmt = FMT_B;
      OP_LUI, OP_AUIPC:                                  fmt = FMT_U;
      OP_JAL:                                            fmt = FMT_J;
      default:                                           fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

  function automatic logic is_base_op(input logic [6:0] opcode);
    return imm_fmt(opcode) != FMT_NONE;
  endfunction

endpackage

// File: rtl/riscv_decode_stage_hazard.sv
// Source-register usage decode and the load-use compare against the instruction in E.
module riscv_decode_stage_hazard
  import riscv_decode_stage_pkg::*;
(
  input  logic       valid,
  input  logic [6:0] opcode,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       load_e,
  input  logic [4:0] rd_e,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       hz
);

  assign uses_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign uses_rs2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  assign hz = valid & load_e & (rd_e != 5'd0) &
              ((uses_rs1 & (rd_e == rs1)) | (uses_rs2 & (rd_e == rs2)));

endmodule

// File: rtl/riscv_decode_stage.sv
// Decode stage: F->D pipeline register, register file with W bypass, load-use interlock,
// immediate generation, illegal-instruction flag and saturating stall counter.
module riscv_decode_stage
  import riscv_decode_stage_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = 32,
  parameter int BYPASS_W = 1,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_validF,
  output logic             o_readyF,
  input  logic [XLEN-1:0]  i_instrF,
  input  logic [XLEN-1:0]  i_PCF,
  input  logic             i_flushD,
  input  logic             i_ldE,
  input  logic [4:0]       i_rd_addrE,
  input  logic             i_wr_enW,
  input  logic [4:0]       i_rd_addrW,
  input  logic [XLEN-1:0]  i_resultW,
  output logic             o_validD,
  input  logic             i_readyE,
  output logic [XLEN-1:0]  o_instrD,
  output logic [XLEN-1:0]  o_PCD,
  output logic [XLEN-1:0]  o_PCPlus4D,
  output logic [4:0]       o_rs1_addrD,
  output logic [4:0]       o_rs2_addrD,
  output logic [4:0]       o_rd_addrD,
  output logic [XLEN-1:0]  o_rs1_dataD,
  output logic [XLEN-1:0]  o_rs2_dataD,
  output logic [XLEN-1:0]  o_immD,
  output logic             o_illegalD,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int AW = $clog2(NREG);

  logic             valid_q;
  logic [XLEN-1:0]  instr_q;
  logic [XLEN-1:0]  pc_q;
  logic [CNT_W-1:0] stall_q;
  logic [XLEN-1:0]  regs [NREG];

  logic             uses_rs1, uses_rs2, uses_rd, hz;
  logic             capture, wr_qual, bad_idx;
  logic [6:0]       opcode;
  logic [31:0]      ins, imm32;
  logic [4:0]       rd_addr [2];
  logic [XLEN-1:0]  rd_data [2];

  assign ins         = instr_q[31:0];
  assign opcode      = ins[6:0];
  assign o_instrD    = instr_q;
  assign o_PCD       = pc_q;
  assign o_PCPlus4D  = pc_q + XLEN'(4);
  assign o_rs1_addrD = ins[19:15];
  assign o_rs2_addrD = ins[24:20];
  assign o_rd_addrD  = ins[11:7];
  assign o_stall_cnt = stall_q;

  riscv_decode_stage_hazard u_hazard (
    .valid    (valid_q),
    .opcode   (opcode),
    .rs1      (o_rs1_addrD),
    .rs2      (o_rs2_addrD),
    .load_e   (i_ldE),
    .rd_e     (i_rd_addrE),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .hz       (hz)
  );

  // A transfer happens on a rising edge where valid and ready are both high; valid never
  // depends on ready. A flush kills both the held instruction and the F offer.
  assign o_validD = valid_q & ~hz & ~i_flushD;
  assign o_readyF = i_flushD | ~valid_q | (i_readyE & ~hz);
  assign capture  = i_validF & o_readyF & ~i_flushD;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      instr_q <= XLEN'(NOP);
      pc_q    <= '0;
    end else if (i_flushD) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      instr_q <= i_instrF;
      pc_q    <= i_PCF;
    end else if (o_validD & i_readyE) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_q <= '0;
    end else if (hz & ~i_flushD & (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  // Writes to x0 or to indices beyond the implemented file are dropped, never aliased.
  assign wr_qual = i_wr_enW & (i_rd_addrW != 5'd0) & (int'(i_rd_addrW) < NREG);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_qual) begin
      regs[i_rd_addrW[AW-1:0]] <= i_resultW;
    end
  end

  assign rd_addr[0] = o_rs1_addrD;
  assign rd_addr[1] = o_rs2_addrD;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      if (rd_addr[p] != 5'd0 && int'(rd_addr[p]) < NREG) begin
        if (BYPASS_W != 0 && wr_qual && rd_addr[p] == i_rd_addrW) rd_data[p] = i_resultW;
        else rd_data[p] = regs[rd_addr[p][AW-1:0]];
      end
    end
  end

  assign o_rs1_dataD = rd_data[0];
  assign o_rs2_dataD = rd_data[1];

  always_comb begin
    imm32 = '0;
    case (imm_fmt(opcode))
      FMT_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   imm32 = {ins[31:12], 12'b0};
      FMT_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign o_immD = XLEN'($signed(imm32));

  assign uses_rd = !(opcode == OP_STORE || opcode == OP_BRANCH);
  assign bad_idx = (uses_rs1 & (int'(o_rs1_addrD) >= NREG)) |
                   (uses_rs2 & (int'(o_rs2_addrD) >= NREG)) |
                   (uses_rd  & (int'(o_rd_addrD)  >= NREG));
  assign o_illegalD = valid_q & (bad_idx | ~is_base_op(opcode));

endmodule
